// File: rtl/sccb_master_if.sv
// Bundles the initializer request/response signals and the SCCB pin controls
// of one SCCB master. The master modport is the sccb_master view. The slave
// modport is the initializer/pin side.
//
// Handshake: the initializer holds ena high with addr/sub_addr/data_wr/rw
// stable. The master takes them on the first clk edge where it is idle and ena
// is 1. busy rises on that same edge and falls when the STOP completes. The
// request fields are ignored while busy is high. ack_err and data_rd stay valid
// from the fall of busy until the next accept.
interface sccb_master_if;
    logic       ena;
    logic [7:0] addr;
    logic [7:0] sub_addr;
    logic [7:0] data_wr;
    logic       rw;
    logic [7:0] data_rd;
    logic       busy;
    logic       ack_err;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        input  ena, addr, sub_addr, data_wr, rw, sda_i,
        output data_rd, busy, ack_err, scl_oe, sda_oe
    );

    modport slave (
        output ena, addr, sub_addr, data_wr, rw, sda_i,
        input  data_rd, busy, ack_err, scl_oe, sda_oe
    );
endinterface

// File: rtl/sccb_master.sv
// SCCB/I2C register master. It runs one write, or one two-phase SCCB read, per
// request on the open-drain SCL/SDA pins. Each bus phase is four quarters of
// CLK_DIV clocks.
module sccb_master #(
    parameter int CLK_DIV = 125
) (
    input  logic                 clk,
    input  logic                 rst,
    sccb_master_if.master        bus,
    output logic [3:0]           dbg_state
);
    typedef enum logic [3:0] {
        IDLE, START, WBYTE, WACK, STOP, RSTART, RADDR, RACK, RBYTE, RNACK, DONE
    } state_e;

    typedef enum logic [1:0] {SEL_ADDR, SEL_SUB, SEL_DATA} sel_e;

    localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);

    state_e      state_q, state_d;
    sel_e        sel_q, sel_d;
    logic [11:0] cnt_q, cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic        second_q, second_d;   // set once the read has entered its second phase
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  data_rd_q, data_rd_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        ack_err_q, ack_err_d;

    logic        tick, sample, phase_end;
    logic [7:0]  tx_byte;
    logic        scl_oe, sda_oe;

    assign tick      = (state_q != IDLE) && (state_q != DONE) && (cnt_q == DIV_LAST);
    assign sample    = tick && (qtr_q == 2'd1);
    assign phase_end = tick && (qtr_q == 2'd3);

    // Byte currently being shifted out: RADDR carries the read address, WBYTE uses the selector
    always_comb begin
        tx_byte = {dev_q, 1'b0};
        if (state_q == RADDR) begin
            tx_byte = {dev_q, 1'b1};
        end else begin
            case (sel_q)
                SEL_SUB:  tx_byte = sub_q;
                SEL_DATA: tx_byte = wdat_q;
                default:  tx_byte = {dev_q, 1'b0};
            endcase
        end
    end

    // Pin drive pattern for the current phase and quarter (1 = pull low)
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            START, RSTART: begin
                sda_oe = (qtr_q != 2'd0);
                scl_oe = (qtr_q == 2'd3);
            end
            WBYTE, RADDR: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe = ~tx_byte[bit_q];
            end
            WACK, RACK, RBYTE, RNACK: begin
                scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
            end
            STOP: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = (qtr_q <= 2'd1);
            end
            default: ;
        endcase
    end

    // Next-state, quarter timing and transaction bookkeeping
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = tick ? 12'd0 : cnt_q + 12'd1;
        qtr_d     = tick ? qtr_q + 2'd1 : qtr_q;
        bit_d     = bit_q;
        second_d  = second_q;
        dev_d     = dev_q;
        sub_d     = sub_q;
        wdat_d    = wdat_q;
        rx_d      = rx_q;
        data_rd_d = data_rd_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;

        case (state_q)
            IDLE: begin
                cnt_d = 12'd0;
                qtr_d = 2'd0;
                if (bus.ena) begin
                    dev_d     = bus.addr[7:1];
                    sub_d     = bus.sub_addr;
                    wdat_d    = bus.data_wr;
                    rw_d      = bus.rw;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    second_d  = 1'b0;
                    sel_d     = SEL_ADDR;
                    bit_d     = 3'd7;
                    state_d   = START;
                end
            end
            START: begin
                if (phase_end) begin
                    sel_d   = SEL_ADDR;
                    bit_d   = 3'd7;
                    state_d = WBYTE;
                end
            end
            WBYTE: begin
                if (phase_end) begin
                    if (bit_q == 3'd0) state_d = WACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            WACK: begin
                if (sample && bus.sda_i) ack_err_d = 1'b1;
                if (phase_end) begin
                    bit_d = 3'd7;
                    if (ack_err_q) begin
                        state_d = STOP;
                    end else begin
                        case (sel_q)
                            SEL_ADDR: begin
                                sel_d   = SEL_SUB;
                                state_d = WBYTE;
                            end
                            SEL_SUB: begin
                                if (rw_q) begin
                                    state_d = STOP;
                                end else begin
                                    sel_d   = SEL_DATA;
                                    state_d = WBYTE;
                                end
                            end
                            default: state_d = STOP;
                        endcase
                    end
                end
            end
            STOP: begin
                if (phase_end) begin
                    if (rw_q && !second_q && !ack_err_q) begin
                        second_d = 1'b1;
                        state_d  = RSTART;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            RSTART: begin
                if (phase_end) begin
                    bit_d   = 3'd7;
                    state_d = RADDR;
                end
            end
            RADDR: begin
                if (phase_end) begin
                    if (bit_q == 3'd0) state_d = RACK;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            RACK: begin
                if (sample && bus.sda_i) ack_err_d = 1'b1;
                if (phase_end) begin
                    bit_d   = 3'd7;
                    state_d = ack_err_q ? STOP : RBYTE;
                end
            end
            RBYTE: begin
                if (sample) rx_d = {rx_q[6:0], bus.sda_i};
                if (phase_end) begin
                    if (bit_q == 3'd0) begin
                        if (!ack_err_q) data_rd_d = rx_q;
                        state_d = RNACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            RNACK: begin
                if (phase_end) state_d = STOP;
            end
            DONE: begin
                cnt_d   = 12'd0;
                qtr_d   = 2'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset releases both lines immediately without a STOP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= SEL_ADDR;
            cnt_q     <= 12'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd7;
            second_q  <= 1'b0;
            dev_q     <= 7'd0;
            sub_q     <= 8'h00;
            wdat_q    <= 8'h00;
            rx_q      <= 8'h00;
            data_rd_q <= 8'h00;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            second_q  <= second_d;
            dev_q     <= dev_d;
            sub_q     <= sub_d;
            wdat_q    <= wdat_d;
            rx_q      <= rx_d;
            data_rd_q <= data_rd_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign bus.scl_oe  = scl_oe;
    assign bus.sda_oe  = sda_oe;
    assign bus.busy    = busy_q;
    assign bus.ack_err = ack_err_q;
    assign bus.data_rd = data_rd_q;
    assign dbg_state   = state_q;
endmodule

// File: doc/sccb_master.md
# sccb_master

SCCB/I2C bus master for the camera configuration path. It accepts one register transaction at a time from the camera initializer over the `ena`/`busy` handshake: a device address, a register sub-address, and either write data or a read request. It executes the transaction on the open-drain SCL/SDA pins and reports read data and acknowledge errors. It sits between the initializer state machine and the camera's SCCB pins.

## Interface
- `CLK_DIV`, default 125: clk cycles per quarter SCL period (125 at 50 MHz gives 100 kHz SCL); legal range 2..4095.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: transaction request, sampled only in IDLE.
- `addr` in 8: device address; bits [7:1] are used, bit 0 is ignored (e.g. 8'hC0).
- `sub_addr` in 8: register address.
- `data_wr` in 8: write data.
- `rw` in 1: 0 = write, 1 = read.
- `data_rd` out 8: byte from the last completed read.
- `busy` out 1: transaction in progress.
- `ack_err` out 1: a slave NACK occurred in the current/last transaction.
- `scl_oe` out 1: 1 = drive SCL low, 0 = release.
- `sda_oe` out 1: 1 = drive SDA low, 0 = release.
- `sda_i` in 1: sampled SDA pin level.

## Operation
- Reset values: `busy`=0, `ack_err`=0, `data_rd`=8'h00, `scl_oe`=0, `sda_oe`=0; FSM goes to IDLE, quarter counter to 0.
- Quarter tick: a counter from 0 to CLK_DIV-1 produces a one-cycle `tick` at wrap. The counter is held at 0 in IDLE. Every bus phase is 4 quarters (q0..q3), and phases advance only on `tick`.
- Accept: in IDLE with `ena`=1, latch `addr`, `sub_addr`, `data_wr`, `rw`, clear `ack_err`, set `busy`=1 on the next edge, and enter START. Inputs are not sampled again until IDLE.
- START, quarters q0..q3:
  - q0: SCL and SDA released.
  - q1: SDA low.
  - q2: SDA low.
  - q3: SCL low.
- Data bit, quarters q0..q3:
  - q0: SCL low, SDA set to the bit (0 = drive low, 1 = release).
  - q1: SCL released.
  - q2: SCL released.
  - q3: SCL low.
  - Sample `sda_i` on the tick ending q1.
  - Bytes go MSB first.
- ACK slot: SDA released for the 9th bit. A sampled 1 sets `ack_err`=1 and jumps to STOP; the remaining phases are skipped.
- STOP, quarters q0..q3:
  - q0: SCL low, SDA low.
  - q1: SCL released.
  - q2: SDA released.
  - q3: both released.
- Write sequence: START, {addr[7:1],0}, ACK, sub_addr, ACK, data_wr, ACK, STOP, IDLE.
- Read sequence (SCCB two-phase, with a full stop between phases):
  - Phase 1: START, {addr[7:1],0}, ACK, sub_addr, ACK, STOP.
  - Phase 2: START, {addr[7:1],1}, ACK, READ8, master NACK, STOP, IDLE.
  - READ8 keeps SDA released and shifts in 8 samples. The master NACK bit releases SDA for the 9th bit.
- `data_rd` updates only after the 8th read bit, and only on a read with no `ack_err`. It holds otherwise.
- No clock stretching: SCL is never sampled.
- FSM states: IDLE, START, WBYTE, WACK, STOP, RSTART, RADDR, RACK, RBYTE, RNACK, DONE. Bit index 7..0; the phase selector (addr/sub/data) picks the WBYTE source.

## Timing
- Write: busy rises 1 cycle after `ena` is sampled. Busy lasts (4+27·4+4)=116 quarters = 116·CLK_DIV cycles, then falls in DONE→IDLE.
- Read: busy lasts (4+18·4+4)+(4+18·4+4)=160 quarters.
- NACK abort: busy ends 4 quarters (the STOP) after the failing ACK slot.
- `busy` is low for at least 1 cycle between transactions. `ena` held high across DONE starts the next transaction on the first IDLE cycle, which serves the initializer's raise-until-busy, drop, wait-for-!busy pattern.
- `rst` mid-transaction: both lines are released and all outputs return to reset values on the next edge. No STOP is generated.
- `ack_err` stays valid from DONE until the next accept.

## Test plan
- Write with CLK_DIV=4: addr=C0, sub=11, data=04, slave ACKs.
  - Bus decodes START, C0, 11, 04, STOP.
  - busy is high exactly 464 cycles; ack_err=0.
- Read with CLK_DIV=4: addr=C0, sub=0A, slave returns 76.
  - Bus shows C0/0A/STOP, then C1/76/NACK/STOP.
  - data_rd=76, busy 640 cycles.
- NACK on device address (pull-up only, no slave):
  - ack_err=1 and STOP follows the first ACK slot.
  - busy = (4+36+4)·4 = 176 cycles; data_rd unchanged.
- Back-to-back: initializer model sends 8 writes (11/04, 14/20, 39/40, 28/E0, 17/38, 18/6A, 19/03, 1A/35).
  - The slave model logs all 8 in order.
- Reset asserted mid data byte:
  - Next edge: scl_oe=0, sda_oe=0, busy=0.
  - A new `ena` then completes a clean write.
- `ena` held high for 1 cycle only:
  - Exactly one transaction runs.
  - Changing `data_wr` during busy does not alter the bus byte.
